slot_reel_gen: RTL and testbench

- Upstream stage of the slot machine FSM. Generates the three 4-bit BCD reel digits (slotNums) that the FSM latches and displays.
- Each reel is a mod-10 counter that steps at its own prescaled rate while slotRunning from the FSM is high.
- When slotRunning falls, the reels stop in sequence: reel 0, then reel 1, then reel 2. A settled flag is raised once all three are frozen.

---
 rtl/slot_reel_gen.sv | 168 ++++++++++++++++
 tb/tb_slot_reel_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_reel_gen.sv
// ---------------------------------------------------------------------------
// slot_reel_gen
//
// Upstream stage of the slot machine FSM. Produces three BCD reel digits that
// free-run at individually prescaled rates while the FSM requests a spin, and
// stops them one after another (reel 0, reel 1, reel 2) once the request
// drops. A settled flag tells the FSM when every reel is frozen.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   slotRunning  spin request from the slot FSM (level, sampled every cycle)
//   slotNums     registered reel digits, each 0..9 (slotNums[i] = reel i)
//   spinning     bit i high while reel i is moving this cycle
//   reelsSettled high when all reels are frozen (state IDLE)
//
// Optional feature macro: SLOT_STOP_JITTER_EN
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4) stretches every stop
//   gap by 0..3 cycles, captured from lfsr[1:0] on entry into each stop state.
//   When undefined, no LFSR exists and each gap is exactly STOP_GAP cycles.
// ---------------------------------------------------------------------------
module slot_reel_gen #(
    parameter int         DIV0      = 3,
    parameter int         DIV1      = 5,
    parameter int         DIV2      = 7,
    parameter int         STOP_GAP  = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slotRunning,
    output logic [2:0][3:0] slotNums,
    output logic [2:0]      spinning,
    output logic            reelsSettled
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        STOP1 = 2'd2,
        STOP2 = 2'd3
    } state_t;

    // Wide enough for STOP_GAP-1 plus the largest jitter extension of 3.
    localparam int GW = $clog2(STOP_GAP + 4);

    state_t          state;
    state_t          next_state;
    logic [GW-1:0]   gap;
    logic [GW-1:0]   gap_limit;
    logic            gap_done;
    logic            entering_stop;

    assign entering_stop = (next_state != state) &&
                           ((next_state == STOP1) || (next_state == STOP2));

`ifdef SLOT_STOP_JITTER_EN
    logic [7:0] lfsr;
    logic [1:0] jit;

    // Free-running LFSR; it keeps stepping in IDLE so the stop timing depends
    // on how long the machine sat idle, not just on the spin length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Jitter for the gap that is about to start is frozen at the entry edge
    // so the terminal count stays stable for the whole gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jit <= 2'd0;
        end else if (entering_stop) begin
            jit <= lfsr[1:0];
        end
    end

    assign gap_limit = GW'(STOP_GAP - 1) + GW'(jit);
`else
    assign gap_limit = GW'(STOP_GAP - 1);
`endif

    assign gap_done = (gap == gap_limit);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A renewed spin request always wins over the gap
    // terminal count so a late re-press is never lost.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (slotRunning) next_state = SPIN;
            SPIN:    if (!slotRunning) next_state = STOP1;
            STOP1: begin
                if (slotRunning)   next_state = SPIN;
                else if (gap_done) next_state = STOP2;
            end
            STOP2: begin
                if (slotRunning)   next_state = SPIN;
                else if (gap_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Gap counter: cleared on every state change, counts only while stopping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap <= '0;
        end else if (next_state != state) begin
            gap <= '0;
        end else if ((state == STOP1) || (state == STOP2)) begin
            gap <= gap + GW'(1);
        end else begin
            gap <= '0;
        end
    end

    // Output decode straight from the state so reset clears it immediately.
    always_comb begin
        spinning = 3'b000;
        case (state)
            SPIN:    spinning = 3'b111;
            STOP1:   spinning = 3'b110;
            STOP2:   spinning = 3'b100;
            default: spinning = 3'b000;
        endcase
    end

    assign reelsSettled = (state == IDLE);

    // One prescaler + mod-10 digit per reel. A frozen reel keeps both its
    // digit and its prescaler phase so a resumed spin continues seamlessly.
    for (genvar i = 0; i < 3; i++) begin : g_reel
        localparam int D  = (i == 0) ? DIV0 : (i == 1) ? DIV1 : DIV2;
        localparam int PW = (D > 1) ? $clog2(D) : 1;

        logic [PW-1:0] pc;
        logic [3:0]    digit;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pc    <= '0;
                digit <= 4'd0;
            end else if (spinning[i]) begin
                if (pc == PW'(D - 1)) begin
                    pc    <= '0;
                    digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                end else begin
                    pc <= pc + PW'(1);
                end
            end
        end

        assign slotNums[i] = digit;
    end

endmodule

// File: tb/tb_slot_reel_gen.sv
// ---------------------------------------------------------------------------
// tb_slot_reel_gen
//
// Self-checking bench for slot_reel_gen with default parameters. The reference
// model tracks, per reel, how many cycles it has been moving; the expected
// digit is simply (moving cycles / divider) mod 10. The moving mask follows
// the stop schedule expressed as "cycles since the request dropped".
// With SLOT_STOP_JITTER_EN defined the exact stop schedule is not modelled;
// instead gap lengths are range-checked and compared across two equal runs.
// ---------------------------------------------------------------------------
module tb_slot_reel_gen;

    localparam int DIVV [3] = '{3, 5, 7};
    localparam int G        = 4;

    logic            clk;
    logic            rst;
    logic            slotRunning;
    logic [2:0][3:0] slotNums;
    logic [2:0]      spinning;
    logic            reelsSettled;

    int total;
    int bad;

    // Reference model state.
    int         mMove [3];
    logic [2:0] mMask;
    int         mStopAge;

    slot_reel_gen dut (
        .clk          (clk),
        .rst          (rst),
        .slotRunning  (slotRunning),
        .slotNums     (slotNums),
        .spinning     (spinning),
        .reelsSettled (reelsSettled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence.
    initial begin
        #400000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expDigit(input int i);
        return 32'((mMove[i] / DIVV[i]) % 10);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) mMove[i] = 0;
        mMask    = 3'b000;
        mStopAge = 0;
    endtask

    // Drive the request for one cycle, advance the model across the edge,
    // and leave time 1 unit after the edge for sampling.
    task automatic applyStimulus(input logic sr);
        slotRunning = sr;
        @(posedge clk);
        for (int i = 0; i < 3; i++) if (mMask[i]) mMove[i]++;
        if (mMask == 3'b000) begin
            if (sr) mMask = 3'b111;
        end else if (mMask == 3'b111) begin
            if (!sr) begin
                mStopAge = 0;
                mMask    = 3'b110;
            end
        end else if (sr) begin
            mMask = 3'b111;
        end else begin
            mStopAge++;
            mMask = (mStopAge < G) ? 3'b110 : (mStopAge < 2 * G) ? 3'b100 : 3'b000;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("%s.range%0d", tag, i), 32'(slotNums[i] <= 4'd9), 32'd1);
`ifndef SLOT_STOP_JITTER_EN
            checkVal($sformatf("%s.digit%0d", tag, i), 32'(slotNums[i]), expDigit(i));
`endif
        end
`ifndef SLOT_STOP_JITTER_EN
        checkVal({tag, ".spinning"}, 32'(spinning), 32'(mMask));
        checkVal({tag, ".settled"}, 32'(reelsSettled), 32'(mMask == 3'b000));
`endif
    endtask

    task automatic doReset();
        rst = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

`ifdef SLOT_STOP_JITTER_EN
    task automatic measureGaps(output int g1, output int g2);
        doReset();
        repeat (21) applyStimulus(1'b1);
        applyStimulus(1'b0);
        g1 = 0;
        while (spinning == 3'b110 && g1 < 50) begin
            g1++;
            applyStimulus(1'b0);
        end
        g2 = 0;
        while (spinning == 3'b100 && g2 < 50) begin
            g2++;
            applyStimulus(1'b0);
        end
        checkOutput("jitterEnd");
        checkVal("jitterSettled", 32'(reelsSettled), 32'd1);
    endtask
`endif

    initial begin
        logic [3:0] held;
        int         lvl;
        int         len;
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        slotRunning = 1'b0;
        modelReset();

        // 1. Reset and idle stability.
        doReset();
        checkOutput("reset");
        checkVal("resetNums", 32'(slotNums), 32'd0);
        checkVal("resetSpin", 32'(spinning), 32'd0);
        checkVal("resetSettled", 32'(reelsSettled), 32'd1);
        repeat (20) begin
            applyStimulus(1'b0);
            checkOutput("idle");
        end
        checkVal("idleNums", 32'(slotNums), 32'd0);

        // 2. Free spin: entry edge, then exactly 30 SPIN cycles; the 30th
        //    cycle sees the request drop, so after it the reels read 0/6/4.
        applyStimulus(1'b1);
        checkVal("spinEntry", 32'(spinning), 32'b111);
        repeat (29) begin
            applyStimulus(1'b1);
            checkOutput("spin");
        end
        applyStimulus(1'b0);
        checkVal("free30.r0", 32'(slotNums[0]), 32'd0);
        checkVal("free30.r1", 32'(slotNums[1]), 32'd6);
        checkVal("free30.r2", 32'(slotNums[2]), 32'd4);
        checkOutput("drop");

        // 3. Staggered stop.
        held = slotNums[0];
`ifndef SLOT_STOP_JITTER_EN
        for (int k = 1; k <= 9; k++) begin
            checkVal($sformatf("stop%0d.spinning", k), 32'(spinning),
                     (k <= 4) ? 32'b110 : (k <= 8) ? 32'b100 : 32'b000);
            checkVal($sformatf("stop%0d.settled", k), 32'(reelsSettled), 32'(k == 9));
            checkVal($sformatf("stop%0d.r0held", k), 32'(slotNums[0]), 32'(held));
            checkOutput("stop");
            if (k < 9) applyStimulus(1'b0);
        end
`else
        repeat (20) begin
            applyStimulus(1'b0);
            checkVal("stopR0held", 32'(slotNums[0]), 32'(held));
        end
`endif

        // 4. Resume two cycles into STOP1.
        repeat (8) applyStimulus(1'b1);
        applyStimulus(1'b0);
        held = slotNums[0];
        applyStimulus(1'b0);
        checkVal("resume.r0held", 32'(slotNums[0]), 32'(held));
        checkVal("resume.stop1", 32'(spinning), 32'b110);
        applyStimulus(1'b1);
        checkVal("resume.spinning", 32'(spinning), 32'b111);
        checkVal("resume.settled", 32'(reelsSettled), 32'd0);
        checkVal("resume.r0same", 32'(slotNums[0]), 32'(held));
        checkOutput("resume");
        repeat (6) begin
            applyStimulus(1'b1);
            checkOutput("resumeSpin");
        end

        // 5. Asynchronous reset between edges while spinning.
        checkVal("preReset.spin", 32'(spinning), 32'b111);
        #2;
        rst = 1'b0;
        #1;
        checkVal("asyncRst.nums", 32'(slotNums), 32'd0);
        checkVal("asyncRst.spin", 32'(spinning), 32'd0);
        checkVal("asyncRst.settled", 32'(reelsSettled), 32'd1);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            applyStimulus(1'b0);
            checkOutput("postReset");
        end

        // Randomized request patterns held for random run lengths.
        repeat (25) begin
            lvl = $urandom % 2;
            len = $urandom_range(1, 14);
            repeat (len) begin
                applyStimulus(lvl[0]);
                checkOutput("rand");
            end
        end

`ifdef SLOT_STOP_JITTER_EN
        // 6. Jitter: each gap in 4..7, and identical runs give identical gaps.
        begin
            int a1, a2, b1, b2;
            measureGaps(a1, a2);
            measureGaps(b1, b2);
            checkVal("jit.gap1range", 32'(a1 >= 4 && a1 <= 7), 32'd1);
            checkVal("jit.gap2range", 32'(a2 >= 4 && a2 <= 7), 32'd1);
            checkVal("jit.repeat1", 32'(b1), 32'(a1));
            checkVal("jit.repeat2", 32'(b2), 32'(a2));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
